// File: rtl/sap1_pkg.sv
// SAP-1 shared constants: opcodes, control-word bit positions, idle word and
// one-hot ring states used by the controller-sequencer.
package sap1_pkg;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Control-word bit order, MSB first: C_P E_P L_M_bar CE_bar L_I_bar E_I_bar
    // L_A_bar E_A S_U E_U L_B_bar L_O_bar.
    localparam int CW_C_P     = 11;
    localparam int CW_E_P     = 10;
    localparam int CW_L_M_BAR = 9;
    localparam int CW_CE_BAR  = 8;
    localparam int CW_L_I_BAR = 7;
    localparam int CW_E_I_BAR = 6;
    localparam int CW_L_A_BAR = 5;
    localparam int CW_E_A     = 4;
    localparam int CW_S_U     = 3;
    localparam int CW_E_U     = 2;
    localparam int CW_L_B_BAR = 1;
    localparam int CW_L_O_BAR = 0;

    localparam logic [11:0] IDLE_CW = 12'b0011_1110_0011;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

endpackage

// File: rtl/controller_sequencer_if.sv
// Opcode in, control word / ring state / halt status out, between the
// controller-sequencer (master) and the SAP-1 datapath (slave).
interface controller_sequencer_if;

    logic [3:0] opcode;
    logic       C_P, E_P, L_M_bar, CE_bar, L_I_bar, E_I_bar;
    logic       L_A_bar, E_A, S_U, E_U, L_B_bar, L_O_bar;
    logic [5:0] T_state;
    logic       HLT_bar;

    modport master (
        input  opcode,
        output C_P, E_P, L_M_bar, CE_bar, L_I_bar, E_I_bar,
        output L_A_bar, E_A, S_U, E_U, L_B_bar, L_O_bar,
        output T_state, HLT_bar
    );

    modport slave (
        output opcode,
        input  C_P, E_P, L_M_bar, CE_bar, L_I_bar, E_I_bar,
        input  L_A_bar, E_A, S_U, E_U, L_B_bar, L_O_bar,
        input  T_state, HLT_bar
    );

endinterface

// File: rtl/ring_counter_6.sv
// Six-state one-hot ring, advancing on the falling clock edge; clear forces T1
// and hold freezes the current state.
module ring_counter_6
    import sap1_pkg::*;
(
    input  logic       clk,
    input  logic       clr_n,
    input  logic       hold,
    output logic [5:0] t_state
);

    always_ff @(negedge clk or negedge clr_n) begin
        if (!clr_n)
            t_state <= T1;
        else if (!hold)
            t_state <= {t_state[4:0], t_state[5]};
    end

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 controller-sequencer: ring counter plus combinational instruction
// decode producing the 12-bit control word for fetch and execute.
module controller_sequencer
    import sap1_pkg::*;
(
    input  logic                  CLK,
    input  logic                  CLR_bar,
    controller_sequencer_if.master bus
);

    logic [5:0]  t_state;
    logic        halted;
    logic [11:0] cw;

    ring_counter_6 u_ring (
        .clk     (CLK),
        .clr_n   (CLR_bar),
        .hold    (halted),
        .t_state (t_state)
    );

    // Sets on the same falling edge that enters T4, so the ring freezes there.
    always_ff @(negedge CLK or negedge CLR_bar) begin
        if (!CLR_bar)
            halted <= 1'b0;
        else if (t_state == T3 && bus.opcode == OP_HLT)
            halted <= 1'b1;
    end

    always_comb begin
        cw = IDLE_CW;
        if (CLR_bar && !halted) begin
            case (t_state)
                T1: begin
                    cw[CW_E_P]     = 1'b1;
                    cw[CW_L_M_BAR] = 1'b0;
                end
                T2: cw[CW_C_P] = 1'b1;
                T3: begin
                    cw[CW_CE_BAR]  = 1'b0;
                    cw[CW_L_I_BAR] = 1'b0;
                end
                T4: begin
                    case (bus.opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            cw[CW_E_I_BAR] = 1'b0;
                            cw[CW_L_M_BAR] = 1'b0;
                        end
                        OP_OUT: begin
                            cw[CW_E_A]     = 1'b1;
                            cw[CW_L_O_BAR] = 1'b0;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    case (bus.opcode)
                        OP_LDA: begin
                            cw[CW_CE_BAR]  = 1'b0;
                            cw[CW_L_A_BAR] = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            cw[CW_CE_BAR]  = 1'b0;
                            cw[CW_L_B_BAR] = 1'b0;
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
                        cw[CW_E_U]     = 1'b1;
                        cw[CW_S_U]     = (bus.opcode == OP_SUB);
                        cw[CW_L_A_BAR] = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.C_P     = cw[CW_C_P];
    assign bus.E_P     = cw[CW_E_P];
    assign bus.L_M_bar = cw[CW_L_M_BAR];
    assign bus.CE_bar  = cw[CW_CE_BAR];
    assign bus.L_I_bar = cw[CW_L_I_BAR];
    assign bus.E_I_bar = cw[CW_E_I_BAR];
    assign bus.L_A_bar = cw[CW_L_A_BAR];
    assign bus.E_A     = cw[CW_E_A];
    assign bus.S_U     = cw[CW_S_U];
    assign bus.E_U     = cw[CW_E_U];
    assign bus.L_B_bar = cw[CW_L_B_BAR];
    assign bus.L_O_bar = cw[CW_L_O_BAR];
    assign bus.T_state = t_state;
    assign bus.HLT_bar = ~halted;

endmodule

// File: tb/tb_controller_sequencer.sv
// Directed bench for controller_sequencer: fetch/execute words per opcode,
// halt freeze and asynchronous clear, against hand-computed control words.
module tb_controller_sequencer;

    // Hand-computed words, bit order C_P E_P L_M_bar CE_bar L_I_bar E_I_bar
    // L_A_bar E_A S_U E_U L_B_bar L_O_bar.
    localparam logic [11:0] W_IDLE  = 12'h3E3;
    localparam logic [11:0] W_T1    = 12'h5E3;
    localparam logic [11:0] W_T2    = 12'hBE3;
    localparam logic [11:0] W_T3    = 12'h263;
    localparam logic [11:0] W_MEMT4 = 12'h1A3;
    localparam logic [11:0] W_LDAT5 = 12'h2C3;
    localparam logic [11:0] W_ABT5  = 12'h2E1;
    localparam logic [11:0] W_ADDT6 = 12'h3C7;
    localparam logic [11:0] W_SUBT6 = 12'h3CF;
    localparam logic [11:0] W_OUTT4 = 12'h3F2;

    logic CLK = 1'b1;
    logic CLR_bar = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    controller_sequencer_if bus ();

    controller_sequencer dut (
        .CLK     (CLK),
        .CLR_bar (CLR_bar),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    logic [11:0] cw_obs;
    assign cw_obs = {bus.C_P, bus.E_P, bus.L_M_bar, bus.CE_bar, bus.L_I_bar, bus.E_I_bar,
                     bus.L_A_bar, bus.E_A, bus.S_U, bus.E_U, bus.L_B_bar, bus.L_O_bar};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one ring step and sample in the following high phase.
    task automatic step();
        @(negedge CLK);
        @(posedge CLK);
        #1;
    endtask

    // Starts sampled in T1, ends sampled in T1 of the next instruction.
    task automatic run_op(input string nm, input logic [3:0] op,
                          input logic [11:0] e4, input logic [11:0] e5, input logic [11:0] e6);
        bus.opcode = op;
        chk({nm, " T1 state"}, 32'(bus.T_state), 32'h01);
        chk({nm, " T1 cw"}, 32'(cw_obs), 32'(W_T1));
        step();
        chk({nm, " T2 state"}, 32'(bus.T_state), 32'h02);
        chk({nm, " T2 cw"}, 32'(cw_obs), 32'(W_T2));
        step();
        chk({nm, " T3 state"}, 32'(bus.T_state), 32'h04);
        chk({nm, " T3 cw"}, 32'(cw_obs), 32'(W_T3));
        step();
        chk({nm, " T4 state"}, 32'(bus.T_state), 32'h08);
        chk({nm, " T4 cw"}, 32'(cw_obs), 32'(e4));
        step();
        chk({nm, " T5 state"}, 32'(bus.T_state), 32'h10);
        chk({nm, " T5 cw"}, 32'(cw_obs), 32'(e5));
        step();
        chk({nm, " T6 state"}, 32'(bus.T_state), 32'h20);
        chk({nm, " T6 cw"}, 32'(cw_obs), 32'(e6));
        chk({nm, " HLT_bar"}, 32'(bus.HLT_bar), 32'h1);
        step();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.opcode = 4'b0000;
        #12;
        chk("rst state", 32'(bus.T_state), 32'h01);
        chk("rst cw", 32'(cw_obs), 32'(W_IDLE));
        chk("rst HLT_bar", 32'(bus.HLT_bar), 32'h1);
        CLR_bar = 1'b1;
        #1;
        chk("post-rst T1 cw", 32'(cw_obs), 32'(W_T1));

        run_op("LDA", 4'b0000, W_MEMT4, W_LDAT5, W_IDLE);
        run_op("ADD", 4'b0001, W_MEMT4, W_ABT5, W_ADDT6);
        run_op("SUB", 4'b0010, W_MEMT4, W_ABT5, W_SUBT6);
        run_op("OUT", 4'b1110, W_OUTT4, W_IDLE, W_IDLE);
        run_op("NOP", 4'b0101, W_IDLE, W_IDLE, W_IDLE);

        // ADD interrupted mid-T5 by a clear inside a high phase (no clock edge).
        bus.opcode = 4'b0001;
        repeat (4) step();
        chk("abort pre T5", 32'(bus.T_state), 32'h10);
        CLR_bar = 1'b0;
        #1;
        chk("abort state", 32'(bus.T_state), 32'h01);
        chk("abort cw", 32'(cw_obs), 32'(W_IDLE));
        chk("abort HLT_bar", 32'(bus.HLT_bar), 32'h1);
        CLR_bar = 1'b1;
        #1;
        chk("abort release cw", 32'(cw_obs), 32'(W_T1));
        step();
        chk("abort resume T2", 32'(bus.T_state), 32'h02);
        step();
        step();
        step();
        step();
        step();
        chk("abort resume T1", 32'(bus.T_state), 32'h01);

        // HLT: freeze at T4 with idle word.
        bus.opcode = 4'b1111;
        step();
        step();
        chk("HLT T3 HLT_bar", 32'(bus.HLT_bar), 32'h1);
        step();
        chk("HLT T4 state", 32'(bus.T_state), 32'h08);
        chk("HLT T4 HLT_bar", 32'(bus.HLT_bar), 32'h0);
        chk("HLT T4 cw", 32'(cw_obs), 32'(W_IDLE));
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("HLT hold%0d state", i), 32'(bus.T_state), 32'h08);
            chk($sformatf("HLT hold%0d cw", i), 32'(cw_obs), 32'(W_IDLE));
        end
        CLR_bar = 1'b0;
        #1;
        chk("HLT clr state", 32'(bus.T_state), 32'h01);
        chk("HLT clr HLT_bar", 32'(bus.HLT_bar), 32'h1);
        CLR_bar = 1'b1;
        bus.opcode = 4'b0000;
        #1;
        chk("HLT clr T1 cw", 32'(cw_obs), 32'(W_T1));
        step();
        chk("HLT clr resume T2", 32'(bus.T_state), 32'h02);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/controller_sequencer.md
# controller_sequencer

SAP-1 controller-sequencer: a 6-state ring counter (T1–T6) plus an instruction decoder. It drives the 12-bit control word that sequences the program counter, MAR, RAM, instruction register, accumulator, adder/subtractor, B and output registers. It sits beside the instruction register, taking its upper nibble as the opcode, and implements fetch (T1–T3) and execute (T4–T6) for LDA, ADD, SUB, OUT and HLT.

## Interface
- No parameters. Fixed widths: opcode 4 bits, ring 6 bits.
- CLK  in  1  system clock; ring advances on its falling edge.
- CLR_bar  in  1  asynchronous, active-low reset/clear.
- opcode  in  4  instruction register bits [7:4].
- C_P, E_P  out  1 each  program counter count / output enable, active-high.
- L_M_bar  out  1  MAR load, active-low.
- CE_bar  out  1  RAM output enable, active-low.
- L_I_bar, E_I_bar  out  1 each  IR load / IR address-nibble enable, active-low.
- L_A_bar  out  1  accumulator load, active-low.
- E_A  out  1  accumulator output enable, active-high.
- S_U  out  1  0 = add, 1 = subtract.
- E_U  out  1  adder/subtractor output enable, active-high.
- L_B_bar, L_O_bar  out  1 each  B / output register load, active-low.
- T_state  out  6  one-hot ring state, bit 0 = T1.
- HLT_bar  out  1  low once halted.

## Operation
- Idle word: C_P=E_P=E_A=S_U=E_U=0; all *_bar=1.
- Each control word below is the idle word with only the listed signals changed.
- Fetch (all opcodes):
  - T1: E_P=1, L_M_bar=0.
  - T2: C_P=1.
  - T3: CE_bar=0, L_I_bar=0.
- LDA 0000:
  - T4: E_I_bar=0, L_M_bar=0.
  - T5: CE_bar=0, L_A_bar=0.
  - T6: idle.
- ADD 0001:
  - T4: as LDA.
  - T5: CE_bar=0, L_B_bar=0.
  - T6: E_U=1, S_U=0, L_A_bar=0.
- SUB 0010: as ADD, except S_U=1 in T6.
- OUT 1110:
  - T4: E_A=1, L_O_bar=0.
  - T5, T6: idle.
- HLT 1111:
  - On entering T4, the halted flag sets and HLT_bar goes low.
  - Ring freezes at T4 with the idle word.
  - Only CLR_bar low exits the halt.
- Other opcodes are NOPs: idle in T4–T6.
- Ring order is T1→T2→…→T6→T1. Every instruction takes exactly 6 CLK cycles.
- Control outputs are a combinational decode of ring state, opcode and halted flag. Opcode is only used in T4–T6.
- Reset (CLR_bar=0), asynchronous:
  - T_state=000001, halted cleared, HLT_bar=1.
  - All control outputs forced to the idle word while CLR_bar is low.
- Reset mid-instruction aborts immediately with no partial completion.

## Timing
- Ring state and halted flag update on the falling edge of CLK only.
- The control word is stable for the full high phase and across the rising edge of CLK, where the datapath registers and program counter act.
- After CLR_bar rises:
  - T1 decode is active immediately.
  - The first falling edge moves to T2.
- Opcode must be stable from the falling edge that enters T4 through the end of T6. The IR loads at the T3 rising edge, which satisfies this.
- HLT_bar falls on the falling edge that enters T4 of an HLT instruction.
- After that falling edge, T_state stays 001000 and the idle word persists on all later edges.
- CLR_bar asserted coincident with a falling edge: reset wins.

## Structure
- Package sap1_pkg:
  - Opcode constants OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT.
  - 12-bit control-word bit indices.
  - IDLE_CW constant.
  - Ring state one-hot constants T1–T6.
- Sub-module ring_counter_6:
  - Falling-edge one-hot ring with asynchronous active-low clear to T1 and a hold input driven by the halted flag.
- The decoder stays in controller_sequencer as a single combinational block over ring state, opcode and halted flag.

## Test plan
- Reset:
  - Pulse CLR_bar low mid-T5 of an ADD → T_state=000001, idle word during low, HLT_bar=1.
  - After release, E_P=1 and L_M_bar=0.
- LDA (opcode 0000) over 6 falling edges → T_state walks 1,2,4,8,16,32, then back to 1. Control words match the fetch rows and the LDA rows exactly in each T state.
- ADD vs SUB:
  - opcode 0001: in T6, E_U=1, S_U=0, L_A_bar=0.
  - opcode 0010: same T6, but S_U=1.
  - Both: T5 has CE_bar=0, L_B_bar=0.
- OUT and NOP:
  - opcode 1110: in T4, E_A=1, L_O_bar=0; T5 and T6 idle.
  - opcode 0101: T4–T6 idle throughout.
- HLT:
  - opcode 1111 → HLT_bar=0 on entering T4.
  - T_state holds 001000 and the idle word for 10 further cycles.
  - CLR_bar pulse → T1, HLT_bar=1.
- Asynchronous reset check: assert CLR_bar between clock edges → T_state changes without any CLK edge.
